merge_sort_sim: RTL and testbench

//  Self-checking merge-sort engine used as a synthesis/simulation benchmark core.
//  - On request, fills an internal array with pseudo-random words.
//  - Sorts the array ascending with a bottom-up merge sort.
//  - Verifies the order and reports pass/fail on test_return.
//  - Exposes thread-style method handshakes (run/start/join/yield) and a finish_flag register.

---
 rtl/merge_sort_pkg.sv | 14 +
 rtl/merge_sort_ram.sv | 23 ++
 rtl/merge_sort_sim.sv | 180 ++++++++++++++++++
 tb/tb_merge_sort_sim.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/merge_sort_pkg.sv
// Shared types and constants for the merge-sort benchmark engine.
package merge_sort_pkg;

   typedef enum logic [2:0] {IDLE, FILL, MERGE, CHECK, DONE} state_e;

   // Galois right-shift mask for x^32 + x^22 + x^2 + x + 1
   localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
   localparam logic [31:0] DEF_SEED  = 32'hACE1_2345;

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
   endfunction

endpackage

// File: rtl/merge_sort_ram.sv
// One write port, one synchronous read port; one instance per sort bank.
module merge_sort_ram #(
   parameter int N      = 32,
   parameter int DATA_W = 32,
   parameter int AW     = $clog2(N)
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem [N];

   // Write and registered read; read-during-write returns the old word
   always_ff @(posedge clk) begin
      if (we_i) mem[waddr_i] <= wdata_i;
      rdata_o <= mem[raddr_i];
   end

endmodule

// File: rtl/merge_sort_sim.sv
// Merge-sort benchmark core: LFSR fill, bottom-up merge between two banks,
// ordered-scan check, and thread-style method handshakes.
module merge_sort_sim
   import merge_sort_pkg::*;
#(
   parameter int          N      = 32,
   parameter int          DATA_W = 32,
   parameter logic [31:0] SEED   = DEF_SEED
) (
   input  logic clk,
   input  logic reset,
   input  logic test_req,
   output logic test_busy,
   output logic test_return,
   input  logic run_req,
   output logic run_busy,
   input  logic start_req,
   output logic start_busy,
   input  logic join_req,
   output logic join_busy,
   input  logic yield_req,
   output logic yield_busy,
   input  logic finish_flag_in,
   input  logic finish_flag_we,
   output logic finish_flag_out
);

   localparam int             AW  = $clog2(N);
   localparam int             IW  = AW + 1;
   localparam logic [IW-1:0]  NI  = IW'(N);
   localparam logic [IW-1:0]  ONE = IW'(1);

   state_e              state_q;
   logic [31:0]         lfsr_q;
   logic [IW-1:0]       cnt_q, w_q, li_q, le_q, ri_q, re_q, o_q;
   logic [1:0]          ph_q;       // 0: fetch left head, 1: fetch right head, 2: merge
   logic                fr_q;       // which head sits on the RAM output: 1 = right
   logic                src_q;      // bank being read during a pass
   logic [DATA_W-1:0]   lh_q, rh_q, prev_q;
   logic                err_q, ret_q, ff_q, tb_q, rb_q, sb_q;

   logic [AW-1:0]       raddr, waddr;
   logic [DATA_W-1:0]   wdata, rd0, rd1, rd_data, eff_l, eff_r;
   logic                we0, we1, l_ok, r_ok, take_l, chk_fault;
   logic [IW-1:0]       nli, nri, wd;
   logic                unused_yield;

   assign rd_data   = src_q ? rd1 : rd0;
   // The head just consumed is replaced straight from the RAM output, so
   // the merge emits one element per cycle without a refill bubble.
   assign eff_l     = fr_q ? lh_q : rd_data;
   assign eff_r     = fr_q ? rd_data : rh_q;
   assign l_ok      = li_q < le_q;
   assign r_ok      = ri_q < re_q;
   assign take_l    = l_ok && (!r_ok || eff_l <= eff_r);
   assign nli       = li_q + ONE;
   assign nri       = ri_q + ONE;
   assign wd        = w_q << 1;
   assign chk_fault = (state_q == CHECK) && (cnt_q >= IW'(2)) && (prev_q > rd_data);

   assign we0   = (state_q == FILL) || ((state_q == MERGE) && ph_q == 2'd2 && src_q);
   assign we1   = (state_q == MERGE) && ph_q == 2'd2 && !src_q;
   assign waddr = (state_q == FILL) ? cnt_q[AW-1:0] : o_q[AW-1:0];
   assign wdata = (state_q == FILL) ? lfsr_q[DATA_W-1:0] : (take_l ? eff_l : eff_r);

   // Read address: head fetches, next element of the consumed run, or scan index
   always_comb begin
      raddr = '0;
      if (state_q == MERGE) begin
         if (ph_q == 2'd0)      raddr = li_q[AW-1:0];
         else if (ph_q == 2'd1) raddr = ri_q[AW-1:0];
         else                   raddr = take_l ? nli[AW-1:0] : nri[AW-1:0];
      end else if (state_q == CHECK) begin
         raddr = cnt_q[AW-1:0];
      end
   end

   merge_sort_ram #(.N(N), .DATA_W(DATA_W)) u_bank0 (
      .clk(clk), .we_i(we0), .waddr_i(waddr), .wdata_i(wdata),
      .raddr_i(raddr), .rdata_o(rd0)
   );

   merge_sort_ram #(.N(N), .DATA_W(DATA_W)) u_bank1 (
      .clk(clk), .we_i(we1), .waddr_i(waddr), .wdata_i(wdata),
      .raddr_i(raddr), .rdata_o(rd1)
   );

   // Sequencer: launch arbitration, fill, merge passes, scan, result
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         lfsr_q  <= SEED;
         cnt_q   <= '0; w_q  <= '0; li_q <= '0; le_q <= '0;
         ri_q    <= '0; re_q <= '0; o_q  <= '0; ph_q <= '0;
         fr_q    <= 1'b0; src_q <= 1'b0;
         lh_q    <= '0; rh_q <= '0; prev_q <= '0;
         err_q   <= 1'b0; ret_q <= 1'b0; ff_q <= 1'b0;
         tb_q    <= 1'b0; rb_q <= 1'b0; sb_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (test_req || run_req || start_req) begin
               state_q <= FILL;
               cnt_q   <= '0;
               tb_q    <= test_req;
               rb_q    <= !test_req && run_req;
               sb_q    <= !test_req && !run_req;
            end
            FILL: begin
               lfsr_q <= lfsr_step(lfsr_q);
               cnt_q  <= cnt_q + ONE;
               if (cnt_q == IW'(N-1)) begin
                  state_q <= MERGE;
                  ph_q  <= 2'd0; src_q <= 1'b0; w_q <= ONE;
                  li_q  <= '0;   le_q  <= ONE;  ri_q <= ONE;
                  re_q  <= IW'(2); o_q <= '0;
               end
            end
            MERGE: case (ph_q)
               2'd0: ph_q <= 2'd1;
               2'd1: begin
                  lh_q <= rd_data;
                  fr_q <= 1'b1;
                  ph_q <= 2'd2;
               end
               default: begin
                  lh_q <= eff_l;
                  rh_q <= eff_r;
                  fr_q <= !take_l;
                  o_q  <= o_q + ONE;
                  if (take_l) li_q <= nli;
                  else        ri_q <= nri;
                  if (o_q + ONE == re_q) begin
                     ph_q <= 2'd0;
                     if (re_q == NI) begin
                        src_q <= !src_q;
                        if (wd == NI) begin
                           state_q <= CHECK;
                           cnt_q   <= '0;
                           err_q   <= 1'b0;
                        end else begin
                           w_q  <= wd;
                           li_q <= '0; le_q <= wd; ri_q <= wd;
                           re_q <= wd << 1; o_q <= '0;
                        end
                     end else begin
                        li_q <= re_q;      le_q <= re_q + w_q;
                        ri_q <= re_q + w_q; re_q <= re_q + wd;
                     end
                  end
               end
            endcase
            CHECK: begin
               cnt_q <= cnt_q + ONE;
               if (cnt_q != '0) prev_q <= rd_data;
               err_q <= err_q | chk_fault;
               if (cnt_q == NI) state_q <= DONE;
            end
            DONE: begin
               ret_q   <= !err_q;
               ff_q    <= 1'b1;
               tb_q    <= 1'b0; rb_q <= 1'b0; sb_q <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
         // External write wins over the DONE set in the same cycle
         if (finish_flag_we) ff_q <= finish_flag_in;
      end
   end

   assign unused_yield    = yield_req;
   assign test_busy       = tb_q;
   assign run_busy        = rb_q;
   assign start_busy      = sb_q;
   assign test_return     = ret_q;
   assign finish_flag_out = ff_q;
   assign join_busy       = join_req && (state_q != IDLE);
   assign yield_busy      = 1'b0;

endmodule

// File: tb/tb_merge_sort_sim.sv
// Directed bench for merge_sort_sim (N=32, DATA_W=32, default seed).
module tb_merge_sort_sim;
   import merge_sort_pkg::*;

   localparam int N = 32;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic test_req = 0, run_req = 0, start_req = 0, join_req = 0, yield_req = 0;
   logic finish_flag_in = 0, finish_flag_we = 0;
   logic test_busy, test_return, run_busy, start_busy, join_busy, yield_busy, finish_flag_out;

   int n_cmp = 0, n_bad = 0, cyc = 0;
   logic [31:0] srt [N];

   merge_sort_sim dut (
      .clk(clk), .reset(reset),
      .test_req(test_req), .test_busy(test_busy), .test_return(test_return),
      .run_req(run_req), .run_busy(run_busy),
      .start_req(start_req), .start_busy(start_busy),
      .join_req(join_req), .join_busy(join_busy),
      .yield_req(yield_req), .yield_busy(yield_busy),
      .finish_flag_in(finish_flag_in), .finish_flag_we(finish_flag_we),
      .finish_flag_out(finish_flag_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   // Taps 32,22,2,1 as a right-shifting Galois register
   function automatic logic [31:0] ref_step(input logic [31:0] s);
      logic [31:0] r;
      r = s >> 1;
      if (s[0]) begin
         r[31] = ~r[31]; r[21] = ~r[21]; r[1] = ~r[1]; r[0] = ~r[0];
      end
      return r;
   endfunction

   // Expected bank: the 32 words from a fresh seed, sorted ascending
   task automatic build_sorted();
      logic [31:0] s, t;
      s = 32'hACE12345;
      for (int i = 0; i < N; i++) begin srt[i] = s; s = ref_step(s); end
      for (int i = 1; i < N; i++) begin
         t = srt[i];
         for (int j = i; j > 0; j--) begin
            if (srt[j-1] > t) begin srt[j] = srt[j-1]; srt[j-1] = t; end
         end
      end
   endtask

   task automatic chk_bank(input string tag);
      for (int i = 0; i < N; i++) chk($sformatf("%s[%0d]", tag, i), dut.u_bank1.mem[i], srt[i]);
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while ((test_busy || run_busy || start_busy) && n < 500) begin
         @(negedge clk); n++;
      end
      chk({tag, "_lat"}, 32'(n <= 400), 1);
   endtask

   task automatic pulse_test();
      test_req = 1; @(negedge clk); test_req = 0;
   endtask

   initial begin
      int n;
      build_sorted();
      repeat (6) @(negedge clk);
      chk("rst_tbusy", test_busy, 0);
      chk("rst_rbusy", run_busy, 0);
      chk("rst_sbusy", start_busy, 0);
      chk("rst_ret", test_return, 0);
      chk("rst_ff", finish_flag_out, 0);
      chk("rst_ybusy", yield_busy, 0);
      reset = 1;

      // First run, request held; also covers the re-launch gap
      while (cyc < 100) @(negedge clk);
      test_req = 1;
      repeat (2) @(negedge clk);
      chk("t1_busy", test_busy, 1);
      repeat (40) @(negedge clk);
      chk("fill0", dut.u_bank0.mem[0], 32'hACE12345);
      chk("fill1", dut.u_bank0.mem[1], 32'hD65091A1);
      wait_done("t1");
      chk("t1_idle_busy", test_busy, 0);
      chk("t1_ret", test_return, 1);
      chk("t1_ff", finish_flag_out, 1);
      chk_bank("t1_bank");
      @(negedge clk);
      chk("relaunch", test_busy, 1);
      test_req = 0;
      wait_done("t2");
      chk("t2_ret", test_return, 1);

      // Corrupted scan must report failure
      force dut.chk_fault = 1'b1;
      pulse_test();
      wait_done("bad");
      chk("bad_ret", test_return, 0);
      release dut.chk_fault;

      // Simultaneous test+run: test wins
      test_req = 1; run_req = 1;
      @(negedge clk);
      test_req = 0; run_req = 0;
      chk("pri_tbusy", test_busy, 1);
      chk("pri_rbusy", run_busy, 0);
      wait_done("pri");
      chk("pri_ret", test_return, 1);

      // run alone, with join/yield exercised during it
      run_req = 1; join_req = 1; yield_req = 1;
      @(negedge clk);
      run_req = 0;
      chk("run_busy", run_busy, 1);
      chk("run_tbusy", test_busy, 0);
      chk("join_busy", join_busy, 1);
      chk("yield_busy", yield_busy, 0);
      wait_done("run");
      chk("run_ret", test_return, 1);
      chk("join_idle", join_busy, 0);
      join_req = 0; yield_req = 0;

      // start alone
      start_req = 1;
      @(negedge clk);
      start_req = 0;
      chk("start_busy", start_busy, 1);
      wait_done("start");

      // Reset in the middle of merging
      pulse_test();
      repeat (60) @(negedge clk);
      chk("mid_state", 32'(dut.state_q == MERGE), 1);
      reset = 0;
      #1;
      chk("mrst_async", test_busy, 0);
      @(negedge clk);
      chk("mrst_busy", test_busy, 0);
      chk("mrst_ret", test_return, 0);
      chk("mrst_ff", finish_flag_out, 0);
      reset = 1;
      @(negedge clk);

      // Fresh run after reset re-seeds the LFSR
      pulse_test();
      wait_done("post");
      chk("post_ret", test_return, 1);
      chk("post_ff", finish_flag_out, 1);
      chk_bank("post_bank");

      // External clear on the DONE cycle overrides the DONE set
      pulse_test();
      n = 0;
      while (dut.state_q != DONE && n < 500) begin @(negedge clk); n++; end
      chk("ff_done_seen", 32'(n < 500), 1);
      finish_flag_we = 1; finish_flag_in = 0;
      @(negedge clk);
      finish_flag_we = 0;
      chk("ff_override", finish_flag_out, 0);
      chk("ff_busy", test_busy, 0);
      repeat (3) @(negedge clk);
      finish_flag_we = 1; finish_flag_in = 1;
      @(negedge clk);
      finish_flag_we = 0;
      chk("ff_write1", finish_flag_out, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
